// File: rtl/count_snapshot_fifo.sv
// Timestamp FIFO: captures {wrap_tag, count} snapshots of an upstream counter
// and drains them through a valid/ready read port.
module count_snapshot_fifo #(
  parameter int CNT_W      = 4,
  parameter int WRAP_W     = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_W-1:0]        count_in,
  input  logic                    capture,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [WRAP_W+CNT_W-1:0] rd_data,
  output logic [DEPTH_LOG2:0]     level,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow
);

  localparam int W     = WRAP_W + CNT_W;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [W-1:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [WRAP_W-1:0]       wrap_tag;
  logic [WRAP_W-1:0]       tag_eff;
  logic [CNT_W-1:0]        prev_count;
  logic                    wrap;
  logic                    push;
  logic                    pop;
  logic [W-1:0]            word;

  // A decrease in the count means the counter rolled over, whatever its modulus.
  assign wrap    = count_in < prev_count;
  assign tag_eff = wrap_tag + WRAP_W'(wrap);
  assign word    = {tag_eff, count_in};

  assign full     = level == LVL_FULL;
  assign empty    = level == '0;
  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  assign pop  = rd_valid & rd_ready;
  assign push = capture & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      wrap_tag   <= '0;
      prev_count <= '0;
    end else begin
      prev_count <= count_in;
      if (wrap)
        wrap_tag <= wrap_tag + WRAP_W'(1);
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (capture & ~push)
        overflow <= 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage is left unreset; rd_data masks stale entries while empty.
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr] <= word;
  end

endmodule
